alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Registered, parametrised-width ALU; next generation of the 8-bit combinational ALU.
//  Adds a persistent flag register (C/Z/N/V, including overflow) and a valid/ready operand handshake.
//  Adds multi-cycle shift-by-N, plus an optional iterative multiplier.
//  Sits between the CPU operand registers and the writeback stage.
// PARAMETERS
//  WIDTH   8   datapath width in bits (>=4, power of two)
//  SHW     $clog2(WIDTH)   shift-amount width (localparam, derived)
// PORTS
//  clk        in   1      single clock, all logic on posedge
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      op/a/b valid this cycle
//  in_ready   out  1      block can accept an operation
//  op         in   4      operation code (table below)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B / shift amount (b[SHW-1:0])
//  out_valid  out  1      one-cycle pulse: result/flags updated
//  result     out  WIDTH  last completed result, held until next completion
//  flag_c     out  1      carry/borrow flag
//  flag_z     out  1      result == 0
//  flag_n     out  1      result[WIDTH-1]
//  flag_v     out  1      signed overflow
// BEHAVIOUR
//  - Accept when in_valid && in_ready; op, a and b are registered at accept. Later input changes have no effect.
//  - Reset: state=IDLE, in_ready=1, out_valid=0, result=0, all flags=0. Reset aborts any op in flight, with no out_valid.
//  - FSM states: IDLE -> (single-cycle op) IDLE; IDLE -> SHIFT (op 12/13/15-ASR, s!=0); IDLE -> MUL (op15 w/ macro).
//    SHIFT/MUL -> IDLE on the last step. in_ready=1 only in IDLE. in_valid while busy is ignored, not queued.
//  - Latency (accept at cycle T): single-cycle ops -> out_valid at T+1.
//    Shifts -> T+1+s, where s=b[SHW-1:0] (s=0 -> T+1). MUL -> T+1+WIDTH.
//  - Back-to-back: a new accept is allowed in the same cycle out_valid is high.
//  - Z/N always derive from the new result. C/V default to 0 unless listed.
//  - 0 ADD  a+b; C=carry out. V=(a.msb==b.msb)&&(r.msb!=a.msb).
//  - 1 ADC  a+b+flag_c (registered flag); C and V as ADD.
//  - 2 SUB  a-b; C=borrow (a<b unsigned). V=(a.msb!=b.msb)&&(r.msb!=a.msb).
//  - 3 SBC  a-b-flag_c; C=borrow, V as SUB.
//  - 4 OR, 5 AND, 6 NOT(a), 7 XOR, 8 PASS a, 9 PASS b.
//  - 10 NEG  -a; C=(a!=0), V=(a==1<<(WIDTH-1)).
//  - 11 CMP  result all-ones if a<b (unsigned), 0 if equal, 1 if a>b. C and V as SUB.
//  - 12 SHL by s, zero fill; 13 SHR by s, zero fill. One bit per cycle.
//    C = last bit shifted out; s=0 -> result=a, C=0.
//  - 15 see CONFIGURATION.
//  - 14 ROLC: rotate left by 1 through flag_c; new C = a.msb; single-cycle.
//  - All arithmetic is modulo 2^WIDTH. Carry is computed on a WIDTH+1 bit sum.
//  - Flags change only on out_valid; otherwise they hold.
// CONFIGURATION
//  ALU_MUL_EN defined: op15 = MUL, unsigned shift-add, one bit of b per cycle for WIDTH cycles.
//    result = low WIDTH bits of a*b; C=V=(high half != 0).
//  ALU_MUL_EN undefined: op15 = ASR by s, sign fill, SHIFT timing, C = last bit out.
//    No multiplier logic or MUL state is synthesised.
// TESTING (WIDTH=8)
//  - ADD a=FF b=01 -> out_valid at T+1, result=00, C=1 Z=1 N=0 V=0.
//    Then ADC a=10 b=00 -> result=11, C=0.
//  - ADD a=7F b=01 -> 80, N=1 V=1 C=0.
//    SUB a=03 b=05 -> FE, C=1 N=1 V=0.
//    CMP a=05 b=03 -> 01, C=0.
//  - SHL a=81 b=03 -> in_ready low T+1..T+3, out_valid at T+4, result=08, C=0.
//    SHR a=81 b=01 -> 40, C=1, at T+2.
//    SHL b=00 -> a at T+1.
//  - During SHL b=07: pulse in_valid mid-shift -> ignored.
//    Assert reset at T+3 -> next cycle in_ready=1, out_valid stays 0, result=00, flags=0.
//  - NEG a=80 -> 80, V=1 C=1 N=1. NEG a=00 -> 00, C=0 Z=1.
//    ROLC a=80 with flag_c=1 -> 01, C=1.
//  - ALU_MUL_EN: MUL a=10 b=10 -> out_valid at T+9, result=00, C=V=1 Z=1.
//    Without macro: op15 a=80 b=02 -> E0 at T+3, C=0.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with persistent flags, valid/ready handshake and multi-cycle shift/multiply
//
// Purpose:
//   Registers one operation per handshake and produces a result plus C/Z/N/V
//   flags that are held until the next completion. Most operations finish in a
//   single cycle. Shift-by-N moves one bit per cycle. op 15 is either an
//   iterative shift-add multiplier or an arithmetic shift right.
//
// Configuration macro:
//   ALU_MUL_EN  defined   : op 15 = MUL (unsigned shift-add, WIDTH cycles)
//               undefined : op 15 = ASR by b[SHW-1:0], no multiplier hardware
//
// Ports:
//   clk        in   1      clock, all logic on posedge
//   reset      in   1      synchronous active-high reset
//   in_valid   in   1      op/a/b valid this cycle
//   in_ready   out  1      high only when idle
//   op         in   4      operation code
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B / shift amount in b[SHW-1:0]
//   out_valid  out  1      one-cycle pulse when result/flags update
//   result     out  WIDTH  last completed result
//   flag_c     out  1      carry / borrow / last bit shifted out
//   flag_z     out  1      result == 0
//   flag_n     out  1      result msb
//   flag_v     out  1      signed overflow

module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int SHW = $clog2(WIDTH);
  // One extra bit so the multiplier step count (WIDTH) fits.
  localparam int CW  = SHW + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADC  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SBC  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_PASA = 4'd8;
  localparam logic [3:0] OP_PASB = 4'd9;
  localparam logic [3:0] OP_NEG  = 4'd10;
  localparam logic [3:0] OP_CMP  = 4'd11;
  localparam logic [3:0] OP_SHL  = 4'd12;
  localparam logic [3:0] OP_SHR  = 4'd13;
  localparam logic [3:0] OP_ROLC = 4'd14;
  localparam logic [3:0] OP_15   = 4'd15;

  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1
`ifdef ALU_MUL_EN
    , S_MUL = 2'd2
`endif
  } state_t;

  state_t state, state_next;

  // Operation context captured at accept for the multi-cycle paths.
  logic [3:0]       op_q;
  logic [WIDTH-1:0] work_a;   // shift register, or product high half for MUL
  logic [CW-1:0]    cnt;      // remaining steps

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] work_b;   // product low half, multiplier bits shift out of bit 0
  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next;
  logic [WIDTH-1:0] mul_lo_next;
`endif

  logic           accept;
  logic [SHW-1:0] s_in;
  logic           shift_op;

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid && in_ready;
  assign s_in     = b[SHW-1:0];

`ifdef ALU_MUL_EN
  assign shift_op = (op == OP_SHL) || (op == OP_SHR);
`else
  assign shift_op = (op == OP_SHL) || (op == OP_SHR) || (op == OP_15);
`endif

  // ---------------------------------------------------------------------------
  // Single-cycle datapath, evaluated straight from the accepted inputs.
  // ---------------------------------------------------------------------------
  logic             add_cin;
  logic             sub_bin;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;
  logic             add_v;
  logic             sub_v;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  logic             alu_v;

  always_comb begin
    add_cin  = (op == OP_ADC) ? flag_c : 1'b0;
    sub_bin  = (op == OP_SBC) ? flag_c : 1'b0;
    add_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, add_cin};
    // A negative WIDTH+1 bit difference sets the top bit: that is the borrow.
    sub_diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, sub_bin};
    add_v    = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
    sub_v    = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);

    // Default covers shifts by zero: pass a through with C=0.
    alu_r = a;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        alu_r = add_sum[WIDTH-1:0];
        alu_c = add_sum[WIDTH];
        alu_v = add_v;
      end
      OP_SUB, OP_SBC: begin
        alu_r = sub_diff[WIDTH-1:0];
        alu_c = sub_diff[WIDTH];
        alu_v = sub_v;
      end
      OP_OR:   alu_r = a | b;
      OP_AND:  alu_r = a & b;
      OP_NOT:  alu_r = ~a;
      OP_XOR:  alu_r = a ^ b;
      OP_PASA: alu_r = a;
      OP_PASB: alu_r = b;
      OP_NEG: begin
        alu_r = -a;
        alu_c = |a;
        alu_v = (a == MSB_ONLY);
      end
      OP_CMP: begin
        if (sub_diff[WIDTH])
          alu_r = {WIDTH{1'b1}};
        else if (a == b)
          alu_r = {WIDTH{1'b0}};
        else
          alu_r = {{(WIDTH-1){1'b0}}, 1'b1};
        alu_c = sub_diff[WIDTH];
        alu_v = sub_v;
      end
      OP_ROLC: begin
        alu_r = {a[WIDTH-2:0], flag_c};
        alu_c = a[WIDTH-1];
      end
      default: begin
        alu_r = a;
        alu_c = 1'b0;
        alu_v = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // One shift step on the captured value; sh_out is the bit leaving.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sh_next;
  logic             sh_out;

  always_comb begin
    sh_next = work_a;
    sh_out  = 1'b0;
    case (op_q)
      OP_SHL: begin
        sh_out  = work_a[WIDTH-1];
        sh_next = {work_a[WIDTH-2:0], 1'b0};
      end
      OP_SHR: begin
        sh_out  = work_a[0];
        sh_next = {1'b0, work_a[WIDTH-1:1]};
      end
      default: begin
        // Arithmetic right shift: sign bit replicates.
        sh_out  = work_a[0];
        sh_next = {work_a[WIDTH-1], work_a[WIDTH-1:1]};
      end
    endcase
  end

`ifdef ALU_MUL_EN
  // Right-shifting shift-add: conditionally add the multiplicand into the high
  // half, then shift the {carry, high, low} product right by one.
  always_comb begin
    mul_sum     = {1'b0, work_a} + (work_b[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    mul_hi_next = mul_sum[WIDTH:1];
    mul_lo_next = {mul_sum[0], work_b[WIDTH-1:1]};
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  logic             done;
  logic [WIDTH-1:0] done_r;
  logic             done_c;
  logic             done_v;
  logic             load_shift;
  logic             load_mul;

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    done_r     = alu_r;
    done_c     = alu_c;
    done_v     = alu_v;
    load_shift = 1'b0;
    load_mul   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (shift_op && (s_in != '0)) begin
            load_shift = 1'b1;
            state_next = S_SHIFT;
          end
`ifdef ALU_MUL_EN
          else if (op == OP_15) begin
            load_mul   = 1'b1;
            state_next = S_MUL;
          end
`endif
          else begin
            done = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (cnt == CW'(1)) begin
          done       = 1'b1;
          done_r     = sh_next;
          done_c     = sh_out;
          done_v     = 1'b0;
          state_next = S_IDLE;
        end
      end
`ifdef ALU_MUL_EN
      S_MUL: begin
        if (cnt == CW'(1)) begin
          done       = 1'b1;
          done_r     = mul_lo_next;
          done_c     = (mul_hi_next != '0);
          done_v     = (mul_hi_next != '0);
          state_next = S_IDLE;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= '0;
      work_a    <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
`ifdef ALU_MUL_EN
      work_b    <= '0;
      mcand     <= '0;
`endif
    end else begin
      out_valid <= done;
      if (done) begin
        result <= done_r;
        flag_c <= done_c;
        flag_z <= (done_r == '0);
        flag_n <= done_r[WIDTH-1];
        flag_v <= done_v;
      end

      if (load_shift) begin
        op_q   <= op;
        work_a <= a;
        cnt    <= CW'(s_in);
      end else if (state == S_SHIFT) begin
        work_a <= sh_next;
        cnt    <= cnt - CW'(1);
      end

`ifdef ALU_MUL_EN
      if (load_mul) begin
        op_q   <= op;
        work_a <= '0;
        work_b <= b;
        mcand  <= a;
        cnt    <= CW'(WIDTH);
      end else if (state == S_MUL) begin
        work_a <= mul_hi_next;
        work_b <= mul_lo_next;
        cnt    <= cnt - CW'(1);
      end
`endif
    end
  end

  // Without the multiplier there is no MUL load path.
  logic unused_ok;
  assign unused_ok = load_mul;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (WIDTH=8)

module tb_alu_seq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       op = 4'd0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             flag_c;
  logic             flag_z;
  logic             flag_n;
  logic             flag_v;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .result(result),
    .flag_c(flag_c),
    .flag_z(flag_z),
    .flag_n(flag_n),
    .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
    int         lat;
  } vec_t;

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
    int         due;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every out_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.r);
        chk("flag_c", flag_c, e.c);
        chk("flag_z", flag_z, e.z);
        chk("flag_n", flag_n, e.n);
        chk("flag_v", flag_v, e.v);
        chk("latency_cycle", cyc, e.due);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb,
                      input logic [7:0] er, input logic ec, input logic ez,
                      input logic en, input logic ev, input int lat);
    int n_wait;
    n_wait = 0;
    while (!in_ready && n_wait < 200) begin
      @(negedge clk);
      n_wait++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'd0, 32'd1);
      return;
    end
    op = o;
    a = va;
    b = vb;
    in_valid = 1'b1;
    sb.push_back('{er, ec, ez, en, ev, cyc + lat});
    @(negedge clk);
    in_valid = 1'b0;
    // Scramble inputs after accept: they must have no effect.
    op = 4'($urandom);
    a = 8'($urandom);
    b = 8'($urandom);
  endtask

  task automatic drain();
    int n_wait;
    n_wait = 0;
    while (sb.size() != 0 && n_wait < 200) begin
      @(negedge clk);
      n_wait++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    //              op     a      b      r      c     z     n     v    lat
    vecs.push_back('{4'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1}); // ADD carry
    vecs.push_back('{4'd1, 8'h10, 8'h00, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1}); // ADC uses C=1
    vecs.push_back('{4'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1}); // ADD overflow
    vecs.push_back('{4'd2, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0, 1}); // SUB borrow
    vecs.push_back('{4'd3, 8'h10, 8'h05, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0, 1}); // SBC with C=1
    vecs.push_back('{4'd11, 8'h05, 8'h03, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1}); // CMP gt
    vecs.push_back('{4'd11, 8'h03, 8'h05, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1}); // CMP lt
    vecs.push_back('{4'd11, 8'h44, 8'h44, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1}); // CMP eq
    vecs.push_back('{4'd4, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1}); // OR
    vecs.push_back('{4'd5, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1}); // AND
    vecs.push_back('{4'd6, 8'h5A, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1}); // NOT
    vecs.push_back('{4'd7, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1}); // XOR
    vecs.push_back('{4'd8, 8'h80, 8'h12, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1}); // PASS a
    vecs.push_back('{4'd9, 8'h12, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1}); // PASS b
    vecs.push_back('{4'd10, 8'h80, 8'h00, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 1}); // NEG min
    vecs.push_back('{4'd10, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1}); // NEG zero
    vecs.push_back('{4'd10, 8'h01, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1}); // NEG 1
    vecs.push_back('{4'd14, 8'h80, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1}); // ROLC C=1
    vecs.push_back('{4'd14, 8'h40, 8'h00, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1}); // ROLC C=1
    vecs.push_back('{4'd2, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1}); // SUB overflow
    vecs.push_back('{4'd12, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 4}); // SHL 3
    vecs.push_back('{4'd13, 8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 2}); // SHR 1
    vecs.push_back('{4'd12, 8'h55, 8'h00, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1}); // SHL 0
    vecs.push_back('{4'd12, 8'hAB, 8'hF8, 8'hAB, 1'b0, 1'b0, 1'b1, 1'b0, 1}); // only b[2:0] used
    vecs.push_back('{4'd13, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8}); // SHR max
    vecs.push_back('{4'd12, 8'hFF, 8'h07, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 8}); // SHL max
    vecs.push_back('{4'd3, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1}); // SBC C=1
    vecs.push_back('{4'd1, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1}); // ADC overflow
`ifdef ALU_MUL_EN
    vecs.push_back('{4'd15, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 9}); // MUL high set
    vecs.push_back('{4'd15, 8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0, 1'b1, 1'b0, 9}); // MUL fits
    vecs.push_back('{4'd15, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 9}); // MUL max
`else
    vecs.push_back('{4'd15, 8'h80, 8'h02, 8'hE0, 1'b0, 1'b0, 1'b1, 1'b0, 3}); // ASR 2
    vecs.push_back('{4'd15, 8'h81, 8'h01, 8'hC0, 1'b1, 1'b0, 1'b1, 1'b0, 2}); // ASR 1
    vecs.push_back('{4'd15, 8'h7F, 8'h03, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 4}); // ASR positive
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_in_ready", in_ready, 32'd1);
    chk("reset_out_valid", out_valid, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_flags", {flag_c, flag_z, flag_n, flag_v}, 32'd0);
    reset = 1'b0;

    // Table: single-cycle ops go back to back; each shift is followed by an
    // accept in the same cycle its out_valid is high.
    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r,
           vecs[i].c, vecs[i].z, vecs[i].n, vecs[i].v, vecs[i].lat);
    end
    drain();

    // in_ready low for exactly the shift steps
    send(4'd12, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    chk("shl3_ready_t1", in_ready, 32'd0);
    @(negedge clk);
    chk("shl3_ready_t2", in_ready, 32'd0);
    @(negedge clk);
    chk("shl3_ready_t3", in_ready, 32'd0);
    @(negedge clk);
    chk("shl3_ready_t4", in_ready, 32'd1);
    chk("shl3_valid_t4", out_valid, 32'd1);
    drain();

    // Leave non-zero result and flags behind so the abort clears something.
    send(4'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    drain();
    @(negedge clk);

    // Busy-time in_valid is ignored; reset mid-shift aborts with no out_valid.
    op = 4'd12;
    a = 8'hFF;
    b = 8'h07;
    in_valid = 1'b1;
    @(negedge clk);
    op = 4'd0;
    a = 8'h01;
    b = 8'h01;
    in_valid = 1'b1;
    chk("abort_ready_t1", in_ready, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_ready_t2", in_ready, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_in_ready", in_ready, 32'd1);
    chk("abort_out_valid", out_valid, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_flags", {flag_c, flag_z, flag_n, flag_v}, 32'd0);
    repeat (12) @(negedge clk);
    chk("abort_result_held", result, 32'd0);

    // Recovery after reset; ADC sees the cleared carry.
    send(4'd1, 8'h10, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    send(4'd13, 8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    drain();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
